mtm_alu_req_arbiter: RTL
========================

Name: mtm_alu_req_arbiter

Overview:
- Shares one mtm_Alu_core-style datapath between NUM_REQ independent operand sources, e.g. several deserializer channels.
- Grants the core to one requester at a time in round-robin order and sequences a start/done transaction with the core.
- Returns the result to the granted requester, tagged with its index.
- A watchdog synthesises an error response if the core never signals done.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT, 64, cycles to wait for core_done after core_start before aborting (>=2).
- TIMEOUT_CTL, 8'hFF, CTL value returned on a timeout response.

Ports:
- clk  in  1  posedge clock
- rst  in  1  synchronous reset, active high
- req_valid  in  NUM_REQ  per-requester operand frame valid
- req_ready  out  NUM_REQ  one-hot accept; frame taken on the clk edge where valid&ready
- req_A  in  NUM_REQ*32  operand A, requester i at bits [32*i +: 32]
- req_B  in  NUM_REQ*32  operand B, same packing
- req_CTL  in  NUM_REQ*8  control byte, requester i at [8*i +: 8]
- core_start  out  1  one-cycle pulse: core_A/B/CTL valid
- core_A  out  32  registered operand A to core
- core_B  out  32  registered operand B to core
- core_CTL  out  8  registered control to core
- core_done  in  1  one-cycle pulse from core: result valid
- core_C  in  32  core result
- core_CTL_out  in  8  core status/CTL byte
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  $clog2(NUM_REQ)  index of the requester owning the response
- rsp_C  out  32  result data
- rsp_CTL  out  8  result CTL byte
- timeout_err  out  1  one-cycle pulse when a transaction is aborted

Behaviour:
- Reset (synchronous, rst=1 at a posedge): FSM=IDLE; all outputs 0; last-grant pointer = NUM_REQ-1, so requester 0 has first priority; watchdog cleared. Applies in any state; an in-flight transaction is dropped without a response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g = first i with req_valid[i], searching last+1, last+2, ... modulo NUM_REQ.
  - req_ready[g]=1 combinationally in this state only; all other req_ready bits are 0.
  - On that edge, latch req_A/B/CTL[g] into core_A/B/CTL and g into rsp_id; go to ISSUE.
  - No valid requester: stay in IDLE, outputs hold.
- ISSUE:
  - core_start=1 for exactly this one cycle; watchdog loaded with 0.
  - Next state WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - core_done=1: latch core_C->rsp_C, core_CTL_out->rsp_CTL; go to RESP.
  - Watchdog reaches TIMEOUT-1 without core_done: rsp_C=0, rsp_CTL=TIMEOUT_CTL, timeout_err pulses 1 cycle; go to RESP.
  - core_done and timeout in the same cycle: core_done wins, no timeout_err.
- RESP:
  - rsp_valid=1; rsp_id/C/CTL stable until accepted.
  - On rsp_valid&rsp_ready: last pointer := rsp_id; go to IDLE.
  - rsp_valid deasserts the following cycle.
- core_done outside WAIT is ignored and causes no state change.
- core_A/B/CTL hold their values after ISSUE until the next grant.
- Latency:
  - Accept edge to core_start: 1 cycle.
  - core_done to rsp_valid: 1 cycle.
  - Minimum accept-to-accept spacing: 4 cycles with zero-latency core_done and rsp_ready tied high.
- Fairness: a continuously valid requester is granted within NUM_REQ transactions.
- req_valid may drop without a grant; nothing is latched in that case.

Decomposition:
- Package mtm_alu_arb_pkg holds:
  - the FSM state encoding (2-bit localparams ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP);
  - the data widths (DATA_W=32, CTL_W=8);
  - the default TIMEOUT_CTL.
- One sub-module: mtm_alu_rr_picker.
  - Combinational rotate-priority encoder.
  - Inputs: req vector and last pointer. Outputs: one-hot grant and index.
  - Unit-tested separately.
- The FSM, watchdog and data registers stay in the top module.

Test Plan:
- Single request: req_valid=01, A=32'h5, B=32'h3, CTL=8'h10; core_done 3 cycles after core_start with C=32'h8, CTL_out=8'h20 -> core_A=5, core_B=3; rsp_valid with rsp_id=0, rsp_C=8, rsp_CTL=8'h20; rsp_valid 1 cycle after core_done.
- Round robin: req_valid=11 held for 4 transactions -> grant order 0,1,0,1; each rsp_id matches its grant.
- Timeout: TIMEOUT=8, core_done never asserted -> timeout_err pulses on the 8th WAIT cycle; rsp_C=0, rsp_CTL=8'hFF; next grant proceeds normally.
- Boundary: core_done on the same cycle the watchdog hits TIMEOUT-1 -> real result returned, timeout_err stays 0.
- Backpressure: rsp_ready=0 for 10 cycles with req_valid=11 -> rsp fields stable, req_ready=00, no core_start until the response is accepted.
- Reset mid-transaction: rst=1 in WAIT with core_done arriving afterwards -> all outputs 0, FSM in IDLE, no rsp_valid; first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/mtm_alu_arb_pkg.sv
// mtm_alu_arb_pkg: shared state encoding, data widths and defaults for the ALU request arbiter.
package mtm_alu_arb_pkg;
    localparam int DATA_W = 32;
    localparam int CTL_W = 8;
    localparam logic [CTL_W-1:0] DEF_TIMEOUT_CTL = 8'hFF;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;
    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT = ST_WAIT,
        S_RESP = ST_RESP
    } state_t;
endpackage

// File: rtl/mtm_alu_rr_picker.sv
// mtm_alu_rr_picker: rotate-priority encoder, searching last+1, last+2, ... modulo NUM_REQ.
module mtm_alu_rr_picker #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);
    int c;
    always_comb begin
        grant = '0;
        idx = '0;
        any = 1'b0;
        c = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = (int'(last) + k) % NUM_REQ;
            if (!any && req[c]) begin
                any = 1'b1;
                idx = $clog2(NUM_REQ)'(c);
            end
        end
        if (any) grant[idx] = 1'b1;
    end
endmodule

// File: rtl/mtm_alu_req_arbiter.sv
// mtm_alu_req_arbiter: round-robin sharing of one ALU core between NUM_REQ requesters, with a done watchdog.
module mtm_alu_req_arbiter
    import mtm_alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64,
    parameter logic [CTL_W-1:0] TIMEOUT_CTL = DEF_TIMEOUT_CTL
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_A,
    input  logic [NUM_REQ*DATA_W-1:0]   req_B,
    input  logic [NUM_REQ*CTL_W-1:0]    req_CTL,
    output logic                        core_start,
    output logic [DATA_W-1:0]           core_A,
    output logic [DATA_W-1:0]           core_B,
    output logic [CTL_W-1:0]            core_CTL,
    input  logic                        core_done,
    input  logic [DATA_W-1:0]           core_C,
    input  logic [CTL_W-1:0]            core_CTL_out,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]           rsp_C,
    output logic [CTL_W-1:0]            rsp_CTL,
    output logic                        timeout_err
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT);
    state_t state, next;
    logic [IW-1:0] last, gidx;
    logic [NUM_REQ-1:0] grant;
    logic any, tmo;
    logic [WW-1:0] wd;

    mtm_alu_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req(req_valid),
        .last(last),
        .grant(grant),
        .idx(gidx),
        .any(any)
    );

    // core_done wins over a coincident watchdog expiry
    assign tmo = state == S_WAIT && !core_done && wd == WW'(TIMEOUT - 1);
    assign req_ready = state == S_IDLE ? grant : '0;
    assign core_start = state == S_ISSUE;
    assign rsp_valid = state == S_RESP;
    assign timeout_err = tmo;

    always_comb begin
        next = state;
        case (state)
            S_IDLE:  next = any ? S_ISSUE : S_IDLE;
            S_ISSUE: next = S_WAIT;
            S_WAIT:  next = (core_done || tmo) ? S_RESP : S_WAIT;
            S_RESP:  next = rsp_ready ? S_IDLE : S_RESP;
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            last <= IW'(NUM_REQ - 1);
            wd <= '0;
            core_A <= '0;
            core_B <= '0;
            core_CTL <= '0;
            rsp_id <= '0;
            rsp_C <= '0;
            rsp_CTL <= '0;
        end else begin
            state <= next;
            wd <= state == S_ISSUE ? '0 : state == S_WAIT ? wd + 1'b1 : wd;
            if (state == S_IDLE && any) begin
                core_A <= req_A[DATA_W*gidx +: DATA_W];
                core_B <= req_B[DATA_W*gidx +: DATA_W];
                core_CTL <= req_CTL[CTL_W*gidx +: CTL_W];
                rsp_id <= gidx;
            end
            if (state == S_WAIT && core_done) begin
                rsp_C <= core_C;
                rsp_CTL <= core_CTL_out;
            end else if (tmo) begin
                rsp_C <= '0;
                rsp_CTL <= TIMEOUT_CTL;
            end
            if (state == S_RESP && rsp_ready) last <= rsp_id;
        end
    end
endmodule
